// File: rtl/dht_poll_sched.sv
// rtl/dht_poll_sched.sv - periodic round-robin poll scheduler for NCH DHT11 driver channels
//
// Sweeps the DHT11 driver channels one at a time. Each channel is started,
// watched until it finishes or times out, and its result is stored as the
// last good reading or as an error/timeout flag. After the last channel the
// block waits POLL_TICKS cycles before starting the next sweep.
//
// Optional feature macro: DHT_RETRY_EN
//   defined   - a failed channel is retried up to MAX_RETRY extra times in the
//               same sweep before it is reported as failed
//   undefined - every failure is reported at once and no retry counter exists
//
// Ports
//   i_clk50mhz   in   1        sole clock, rising edge
//   i_rst        in   1        asynchronous active-high reset
//   i_enable     in   1        level, 1 = run periodic sweeps
//   o_drv_en     out  NCH      per-channel driver enable
//   o_drv_rst    out  NCH      per-channel driver reset/start strobe
//   i_drv_wait   in   NCH      per-channel driver busy
//   i_drv_error  in   NCH      per-channel driver error, sampled at completion
//   i_drv_temp   in   8*NCH    driver temperature bytes, channel i at [8i+7:8i]
//   i_drv_hum    in   8*NCH    driver humidity bytes, same packing
//   o_temp       out  8*NCH    last good temperature per channel
//   o_hum        out  8*NCH    last good humidity per channel
//   o_valid      out  NCH      channel holds a reading from its latest sequence
//   o_err        out  NCH      channel's latest sequence failed
//   o_timeout    out  NCH      channel's latest failure was a timeout
//   o_sample_stb out  1        one-cycle pulse per finished channel
//   o_sample_ch  out  3        channel index of the last o_sample_stb
//   o_busy_led   out  1        1 while a transaction is active

module dht_poll_sched #(
  parameter int NCH           = 2,
  parameter int POLL_TICKS    = 100_000_000,
  parameter int TIMEOUT_TICKS = 2_500_000,
  parameter int MAX_RETRY     = 2
) (
  input  logic               i_clk50mhz,
  input  logic               i_rst,
  input  logic               i_enable,
  output logic [NCH-1:0]     o_drv_en,
  output logic [NCH-1:0]     o_drv_rst,
  input  logic [NCH-1:0]     i_drv_wait,
  input  logic [NCH-1:0]     i_drv_error,
  input  logic [8*NCH-1:0]   i_drv_temp,
  input  logic [8*NCH-1:0]   i_drv_hum,
  output logic [8*NCH-1:0]   o_temp,
  output logic [8*NCH-1:0]   o_hum,
  output logic [NCH-1:0]     o_valid,
  output logic [NCH-1:0]     o_err,
  output logic [NCH-1:0]     o_timeout,
  output logic               o_sample_stb,
  output logic [2:0]         o_sample_ch,
  output logic               o_busy_led
);

  // One counter serves both the transaction timeout and the sweep interval,
  // so it is sized for the larger of the two limits.
  localparam int MAX_TICKS = (POLL_TICKS > TIMEOUT_TICKS) ? POLL_TICKS : TIMEOUT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_XFER,
    S_CAPTURE,
    S_NEXT,
    S_INTERVAL,
    S_RETRY_GAP
  } state_t;

  state_t          r_state;
  logic [2:0]      r_ch;
  logic [CW-1:0]   r_cnt;
  logic            r_timed_out;

  logic [NCH-1:0]  w_sel;
  logic [CW-1:0]   w_cnt_next;
  logic            w_wait;
  logic            w_error;
  logic            w_fail;
  logic            w_retry_ok;

  function automatic logic [NCH-1:0] f_onehot(input logic [2:0] ch);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Only the active channel's handshake is looked at; the others are masked.
  assign w_sel      = f_onehot(r_ch);
  assign w_wait     = |(i_drv_wait & w_sel);
  assign w_error    = |(i_drv_error & w_sel);
  assign w_fail     = r_timed_out | w_error;
  // The compare happens on the incremented value, and the counter is never
  // stored beyond the limit, so it cannot wrap before the compare.
  assign w_cnt_next = r_cnt + CW'(1);

`ifdef DHT_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0] r_retry;

  assign w_retry_ok = (r_retry < RW'(MAX_RETRY));

  // Attempts are counted per channel: any final outcome in CAPTURE clears
  // the count so the next channel starts fresh.
  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      r_retry <= '0;
    end else if (r_state == S_CAPTURE) begin
      if (w_fail && w_retry_ok) r_retry <= r_retry + RW'(1);
      else                      r_retry <= '0;
    end
  end
`else
  assign w_retry_ok = 1'b0;
`endif

  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ch         <= '0;
      r_cnt        <= '0;
      r_timed_out  <= 1'b0;
      o_drv_en     <= '0;
      o_drv_rst    <= '0;
      o_temp       <= '0;
      o_hum        <= '0;
      o_valid      <= '0;
      o_err        <= '0;
      o_timeout    <= '0;
      o_sample_stb <= 1'b0;
      o_sample_ch  <= '0;
      o_busy_led   <= 1'b0;
    end else begin
      o_sample_stb <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_ch       <= '0;
            o_drv_en   <= f_onehot(3'd0);
            o_drv_rst  <= f_onehot(3'd0);
            o_busy_led <= 1'b1;
            r_state    <= S_START;
          end
        end

        // Start strobe lasts exactly this one cycle.
        S_START: begin
          o_drv_rst   <= '0;
          r_cnt       <= '0;
          r_timed_out <= 1'b0;
          r_state     <= S_ARM;
        end

        // Timeout has priority over the driver handshake in the same cycle.
        S_ARM: begin
          r_cnt <= w_cnt_next;
          if (w_cnt_next == CW'(TIMEOUT_TICKS)) begin
            r_timed_out <= 1'b1;
            o_drv_en    <= '0;
            r_state     <= S_CAPTURE;
          end else if (w_wait) begin
            r_state <= S_XFER;
          end
        end

        S_XFER: begin
          r_cnt <= w_cnt_next;
          if (w_cnt_next == CW'(TIMEOUT_TICKS)) begin
            r_timed_out <= 1'b1;
            o_drv_en    <= '0;
            r_state     <= S_CAPTURE;
          end else if (!w_wait) begin
            o_drv_en <= '0;
            r_state  <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (!w_fail) begin
            for (int i = 0; i < NCH; i++) begin
              if (w_sel[i]) begin
                o_temp[8*i +: 8] <= i_drv_temp[8*i +: 8];
                o_hum[8*i +: 8]  <= i_drv_hum[8*i +: 8];
              end
            end
            o_valid      <= o_valid | w_sel;
            o_err        <= o_err & ~w_sel;
            o_timeout    <= o_timeout & ~w_sel;
            o_sample_stb <= 1'b1;
            o_sample_ch  <= r_ch;
            o_busy_led   <= 1'b0;
            r_state      <= S_NEXT;
          end else if (w_retry_ok) begin
            // Silent retry: no strobe, the channel is restarted after a gap.
            r_state <= S_RETRY_GAP;
          end else begin
            // Final failure keeps the previous good reading untouched.
            o_valid      <= o_valid & ~w_sel;
            o_err        <= o_err | w_sel;
            o_timeout    <= r_timed_out ? (o_timeout | w_sel) : (o_timeout & ~w_sel);
            o_sample_stb <= 1'b1;
            o_sample_ch  <= r_ch;
            o_busy_led   <= 1'b0;
            r_state      <= S_NEXT;
          end
        end

        // One cycle with every driver disabled before restarting the channel.
        S_RETRY_GAP: begin
          o_drv_en  <= w_sel;
          o_drv_rst <= w_sel;
          r_state   <= S_START;
        end

        // A dropped enable stops the sweep after the channel that just ended.
        S_NEXT: begin
          if (!i_enable) begin
            r_ch    <= '0;
            r_state <= S_IDLE;
          end else if (r_ch < 3'(NCH - 1)) begin
            r_ch       <= r_ch + 3'd1;
            o_drv_en   <= f_onehot(r_ch + 3'd1);
            o_drv_rst  <= f_onehot(r_ch + 3'd1);
            o_busy_led <= 1'b1;
            r_state    <= S_START;
          end else begin
            r_ch    <= '0;
            r_cnt   <= '0;
            r_state <= S_INTERVAL;
          end
        end

        // START is entered exactly POLL_TICKS cycles after INTERVAL entry.
        S_INTERVAL: begin
          if (w_cnt_next == CW'(POLL_TICKS)) begin
            r_cnt <= '0;
            if (i_enable) begin
              o_drv_en   <= f_onehot(3'd0);
              o_drv_rst  <= f_onehot(3'd0);
              o_busy_led <= 1'b1;
              r_state    <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        default: begin
          o_drv_en   <= '0;
          o_drv_rst  <= '0;
          o_busy_led <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht_poll_sched.sv
// tb/tb_dht_poll_sched.sv - scoreboard bench for dht_poll_sched with two driver models

module tb_dht_poll_sched;

  localparam int NCH  = 2;
  localparam int POLL = 100;
  localparam int TOUT = 50;
  localparam int MAXR = 2;
`ifdef DHT_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  drv_en, drv_rst, drv_wait, drv_error;
  logic [15:0] drv_temp, drv_hum, temp, hum;
  logic [1:0]  valid, err, tmo;
  logic        stb;
  logic [2:0]  sch;
  logic        busy;

  logic [7:0]  m_temp [2];
  logic [7:0]  m_hum [2];
  logic [7:0]  g_temp [2];
  logic [7:0]  g_hum [2];
  int          m_phase [2];
  int          n_start [2];
  int          m_err_until [2];
  bit          m_noresp [2];

  int n_checks = 0;
  int n_errors = 0;
  int n_stb    = 0;

  typedef struct {
    int         ch;
    logic [7:0] t;
    logic [7:0] h;
    logic       v;
    logic       e;
    logic       to;
  } exp_t;

  exp_t q[$];

  always #10 clk = ~clk;

  assign drv_temp = {m_temp[1], m_temp[0]};
  assign drv_hum  = {m_hum[1], m_hum[0]};

  dht_poll_sched #(
    .NCH(NCH), .POLL_TICKS(POLL), .TIMEOUT_TICKS(TOUT), .MAX_RETRY(MAXR)
  ) dut (
    .i_clk50mhz(clk), .i_rst(rst), .i_enable(enable),
    .o_drv_en(drv_en), .o_drv_rst(drv_rst),
    .i_drv_wait(drv_wait), .i_drv_error(drv_error),
    .i_drv_temp(drv_temp), .i_drv_hum(drv_hum),
    .o_temp(temp), .o_hum(hum),
    .o_valid(valid), .o_err(err), .o_timeout(tmo),
    .o_sample_stb(stb), .o_sample_ch(sch), .o_busy_led(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input bit ok, input bit to);
    exp_t e;
    if (ok) begin
      g_temp[ch] = m_temp[ch];
      g_hum[ch]  = m_hum[ch];
    end
    e.ch = ch; e.t = g_temp[ch]; e.h = g_hum[ch];
    e.v = ok; e.e = !ok; e.to = to;
    q.push_back(e);
  endtask

  // Driver model: busy rises two cycles after the start strobe and stays up
  // for six cycles; the error flag is raised for attempts up to m_err_until.
  task automatic model();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_phase[i] = 0; drv_wait[i] = 1'b0; drv_error[i] = 1'b0;
        end else if (drv_rst[i]) begin
          n_start[i]++;
          drv_wait[i] = 1'b0; drv_error[i] = 1'b0;
          m_phase[i] = m_noresp[i] ? 0 : 1;
        end else if (m_phase[i] != 0) begin
          m_phase[i]++;
          if (m_phase[i] == 3) drv_wait[i] = 1'b1;
          if (m_phase[i] == 9) begin
            drv_wait[i]  = 1'b0;
            drv_error[i] = (n_start[i] <= m_err_until[i]);
            m_phase[i]   = 0;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (stb) begin
        n_stb++;
        if (q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL stb_unexpected actual_ch=%0d required=none", sch);
        end else begin
          e = q.pop_front();
          chk("sample_ch", sch, e.ch);
          chk("sample_valid", valid[e.ch], e.v);
          chk("sample_err", err[e.ch], e.e);
          chk("sample_timeout", tmo[e.ch], e.to);
          chk("sample_temp", temp[8*e.ch +: 8], e.t);
          chk("sample_hum", hum[8*e.ch +: 8], e.h);
        end
      end
    end
  endtask

  task automatic wait_stb(input int n, input int budget);
    int k = 0;
    while (n_stb < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_stb", n_stb, n);
  endtask

  task automatic watch(input int n, input logic [1:0] mask, output int hits);
    hits = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (((drv_en | drv_rst) & mask) != 2'b00) hits++;
    end
  endtask

  task automatic wait_xfer0();
    int k = 0;
    while (!(drv_en[0] && drv_wait[0]) && k < 100) begin
      @(negedge clk); #1; k++;
    end
    @(negedge clk); #1;
    chk("reach_xfer0", {drv_en[0], drv_wait[0]}, 2'b11);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_drv_en"}, drv_en, 2'b00);
    chk({tag, "_drv_rst"}, drv_rst, 2'b00);
    chk({tag, "_temp"}, temp, 16'h0);
    chk({tag, "_hum"}, hum, 16'h0);
    chk({tag, "_valid"}, valid, 2'b00);
    chk({tag, "_err"}, err, 2'b00);
    chk({tag, "_timeout"}, tmo, 2'b00);
    chk({tag, "_stb"}, stb, 1'b0);
    chk({tag, "_sample_ch"}, sch, 3'd0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    int hits;
    int s0;
    int s_stb;

    rst = 1'b1; enable = 1'b0; drv_wait = 2'b00; drv_error = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_temp[i] = 8'h0; m_hum[i] = 8'h0; g_temp[i] = 8'h0; g_hum[i] = 8'h0;
      m_phase[i] = 0; n_start[i] = 0; m_err_until[i] = 0; m_noresp[i] = 1'b0;
    end
    fork
      model();
      monitor();
    join_none

    repeat (3) @(negedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;

    // Two good channels, then interval timing to the next sweep.
    m_temp[0] = 8'h19; m_hum[0] = 8'h3C; m_temp[1] = 8'h1A; m_hum[1] = 8'h3D;
    push(0, 1'b1, 1'b0); push(1, 1'b1, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    wait_stb(2, 300);
    k = 0;
    while (!drv_rst[0] && k < 300) begin
      @(negedge clk); k++;
    end
    chk("interval_to_start", k, 101);
    chk("sweep_temp", temp, 16'h1A19);
    chk("sweep_hum", hum, 16'h3D3C);
    chk("sweep_valid", valid, 2'b11);
    push(0, 1'b1, 1'b0);
    enable = 1'b0;
    wait_stb(3, 100);
    watch(40, 2'b10, hits);
    chk("disable_no_ch1", hits, 0);
    chk("disable_busy", busy, 1'b0);

    // Channel 1 never answers: timeout after 50 ARM cycles.
    m_temp[0] = 8'h21; m_hum[0] = 8'h41; m_noresp[1] = 1'b1;
    push(0, 1'b1, 1'b0); push(1, 1'b0, 1'b1);
    enable = 1'b1;
    k = 0;
    while (!drv_en[1] && k < 200) begin
      @(negedge clk); k++;
    end
    k = 0;
    while (drv_en[1] && k < 200) begin
      @(negedge clk); k++;
    end
    chk("timeout_en_cycles", k, 51);
    wait_stb(5, 600);
    enable = 1'b0;
    chk("timeout_err", err, 2'b10);
    chk("timeout_flag", tmo, 2'b10);
    chk("timeout_valid", valid, 2'b01);
    chk("timeout_temp", temp, 16'h1A21);
    chk("timeout_hum", hum, 16'h3D41);
    watch(150, 2'b11, hits);
    chk("idle_no_start", hits, 0);

    // Enable dropped while channel 0 is in XFER.
    m_noresp[1] = 1'b0; m_temp[0] = 8'h17; m_hum[0] = 8'h30;
    push(0, 1'b1, 1'b0);
    enable = 1'b1;
    wait_xfer0();
    enable = 1'b0;
    wait_stb(6, 100);
    watch(40, 2'b10, hits);
    chk("xfer_drop_no_ch1", hits, 0);
    chk("xfer_drop_busy", busy, 1'b0);

    // Channel 0 errors on its first two attempts.
    s0 = n_start[0];
    m_err_until[0] = n_start[0] + 2;
    push(0, RETRY_ON, 1'b0); push(1, 1'b1, 1'b0);
    enable = 1'b1;
    wait_stb(8, 800);
    enable = 1'b0;
    chk("err2_starts", n_start[0] - s0, RETRY_ON ? 3 : 1);

    // Channel 0 always errors.
    repeat (5) @(negedge clk);
    s0 = n_start[0];
    m_err_until[0] = n_start[0] + 99;
    push(0, 1'b0, 1'b0); push(1, 1'b1, 1'b0);
    enable = 1'b1;
    wait_stb(10, 800);
    enable = 1'b0;
    chk("errall_starts", n_start[0] - s0, RETRY_ON ? 3 : 1);
    chk("errall_err0", err[0], 1'b1);
    chk("errall_valid0", valid[0], 1'b0);

    // Reset in the middle of a transfer.
    repeat (5) @(negedge clk);
    m_err_until[0] = n_start[0];
    enable = 1'b1;
    wait_xfer0();
    s_stb = n_stb;
    rst = 1'b1;
    #1;
    chk_reset("mid_xfer");
    repeat (3) @(negedge clk);
    #1;
    chk("rst_no_stb", n_stb, s_stb);
    enable = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    chk("total_stb", n_stb, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dht_poll_sched.md
DHT_POLL_SCHED -- requirements
Module: dht_poll_sched

Interface
REQ-001 Parameter NCH, default 2, number of DHT11 driver channels (1..8).
REQ-002 Parameter POLL_TICKS, default 100_000_000, CLK50MHZ cycles between sweeps (2 s).
REQ-003 Parameter TIMEOUT_TICKS, default 2_500_000, per-transaction limit (50 ms).
REQ-004 Parameter MAX_RETRY, default 2, extra attempts per channel per sweep.
REQ-005 CLK50MHZ  in  1  sole clock, all logic on rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 ENABLE  in  1  level; 1 = run periodic sweeps.
REQ-008 DRV_EN  out  NCH  per-channel driver enable.
REQ-009 DRV_RST  out  NCH  per-channel driver reset/start strobe.
REQ-010 DRV_WAIT  in  NCH  per-channel driver busy.
REQ-011 DRV_ERROR  in  NCH  per-channel driver error, sampled at completion.
REQ-012 DRV_TEMP, DRV_HUM  in  8*NCH each  integer bytes; channel i at bits [8i+7:8i].
REQ-013 TEMP, HUM  out  8*NCH each  last good reading per channel, same packing.
REQ-014 VALID  out  NCH  channel holds a reading from the latest attempt sequence.
REQ-015 ERR  out  NCH  channel's latest sequence failed (error or timeout).
REQ-016 TIMEOUT  out  NCH  channel's latest failure was a timeout.
REQ-017 SAMPLE_STB  out  1  one-cycle pulse per finished channel (good or failed).
REQ-018 SAMPLE_CH  out  3  channel index for SAMPLE_STB; held until next pulse.
REQ-019 BUSY_LED  out  1  1 while any transaction is active.

Function
REQ-020 States: IDLE, START, ARM, XFER, CAPTURE, NEXT, INTERVAL; one channel active at a time; all other DRV_EN/DRV_RST bits 0.
REQ-021 IDLE: outputs held; ENABLE=1 -> START, ch=0, retry=0.
REQ-022 START: exactly one cycle DRV_EN[ch]=1, DRV_RST[ch]=1; clear timeout counter -> ARM.
REQ-023 ARM: DRV_EN[ch]=1, DRV_RST[ch]=0; DRV_WAIT[ch]=1 -> XFER.
REQ-024 XFER: DRV_EN[ch]=1; DRV_WAIT[ch]=0 -> CAPTURE.
REQ-025 Timeout counter runs through ARM+XFER; count==TIMEOUT_TICKS -> failure with timeout, DRV_EN[ch]=0 next cycle.
REQ-026 CAPTURE, one cycle, DRV_EN[ch]=0: DRV_ERROR[ch]=0 -> latch TEMP/HUM[ch], VALID[ch]=1, ERR[ch]=0, TIMEOUT[ch]=0, SAMPLE_STB=1 -> NEXT; else failure path.
REQ-027 Final failure: TEMP/HUM[ch] unchanged, VALID[ch]=0, ERR[ch]=1, TIMEOUT[ch]=cause, SAMPLE_STB=1 -> NEXT.
REQ-028 NEXT: ch<NCH-1 -> ch+1, retry=0, START; ch==NCH-1 -> ch=0, INTERVAL.
REQ-029 INTERVAL: counts POLL_TICKS cycles from entry; expiry with ENABLE=1 -> START; ENABLE=0 -> IDLE.
REQ-030 ENABLE falling mid-sweep: current channel completes through CAPTURE/failure, then IDLE; no further channels.
REQ-031 Counter width = clog2(max(POLL_TICKS,TIMEOUT_TICKS)+1); no wrap before compare.
REQ-032 DRV_WAIT/DRV_ERROR of inactive channels ignored.

Reset
REQ-033 RST=1 forces immediately: state IDLE, ch=0, counters 0, DRV_EN=0, DRV_RST=0, TEMP=0, HUM=0, VALID=0, ERR=0, TIMEOUT=0, SAMPLE_STB=0, SAMPLE_CH=0, BUSY_LED=0.
REQ-034 Reset mid-transaction abandons it with no SAMPLE_STB; first START at least one cycle after RST release.

Configuration
REQ-035 DHT_RETRY_EN defined: on failure, if retry<MAX_RETRY, retry+1, one cycle all DRV_EN=0, then START same channel, no SAMPLE_STB; else REQ-027.
REQ-036 DHT_RETRY_EN undefined: every failure goes directly to REQ-027; retry counter absent.

Verification (NCH=2, POLL_TICKS=100, TIMEOUT_TICKS=50, MAX_RETRY=2)
REQ-037 Both models answer TEMP=0x19/HUM=0x3C, 0x1A/0x3D, no error -> TEMP=0x1A19, HUM=0x3D3C, VALID=2'b11, two SAMPLE_STB with SAMPLE_CH 0 then 1; next START 100 cycles after INTERVAL entry.
REQ-038 Channel 1 never raises WAIT, retry off -> DRV_EN[1] drops after 50 cycles in ARM; ERR=2'b10, TIMEOUT=2'b10, VALID[1]=0, TEMP[15:8] unchanged.
REQ-039 Retry on, channel 0 errors twice then succeeds -> three START pulses on ch0, single SAMPLE_STB, VALID[0]=1, ERR[0]=0.
REQ-040 Retry on, channel 0 always errors -> exactly 3 START pulses, ERR[0]=1, VALID[0]=0, sweep proceeds to ch1.
REQ-041 ENABLE dropped during ch0 XFER -> ch0 captured, no START on ch1, state IDLE.
REQ-042 RST pulsed during XFER -> DRV_EN=0 same cycle, all outputs at reset values, no SAMPLE_STB.
